// File: rtl/s1_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : s1_decode_stage
// Purpose  : Stage-1 decode register with ready/valid on both sides and a
//            2-entry skid buffer; stores decoded fields only.
// Revision : 1.0
// ============================================================================
module s1_decode_stage #(
    parameter int OPC_W     = 6,
    parameter int REG_SEL_W = 5,
    parameter int IMM_W     = 16,
    parameter int INSTR_W   = 32,
    parameter int DATA_W    = 32,
    parameter int SIGN_EXT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [INSTR_W-1:0]   InstrIn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [REG_SEL_W-1:0] S1_ReadSelect1,
    output logic [REG_SEL_W-1:0] S1_ReadSelect2,
    output logic [REG_SEL_W-1:0] S1_WriteSelect,
    output logic                 S1_WriteEnable,
    output logic                 S1_DataSrc,
    output logic [2:0]           S1_ALUOp,
    output logic [DATA_W-1:0]    S1_IMM
);

    if (INSTR_W != OPC_W + 2*REG_SEL_W + IMM_W) begin : g_bad_instr_w
        $error("s1_decode_stage: INSTR_W must equal OPC_W + 2*REG_SEL_W + IMM_W");
    end
    if (DATA_W < IMM_W) begin : g_bad_data_w
        $error("s1_decode_stage: DATA_W must be >= IMM_W");
    end
    if (OPC_W < 5) begin : g_bad_opc_w
        $error("s1_decode_stage: OPC_W must be >= 5");
    end

    typedef struct packed {
        logic [REG_SEL_W-1:0] rs1;
        logic [REG_SEL_W-1:0] rs2;
        logic [REG_SEL_W-1:0] ws;
        logic                 we;
        logic                 ds;
        logic [2:0]           alu;
        logic [DATA_W-1:0]    imm;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational field and control decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [OPC_W-1:0]     w_opcode;
    logic [REG_SEL_W-1:0] w_rd;
    logic [REG_SEL_W-1:0] w_rs;
    logic [REG_SEL_W-1:0] w_rt;
    logic [IMM_W-1:0]     w_imm;
    logic [DATA_W-1:0]    w_imm_ext;
    dec_t                 w_dec;

    assign w_opcode = InstrIn[INSTR_W-1 -: OPC_W];
    assign w_rd     = InstrIn[INSTR_W-OPC_W-1 -: REG_SEL_W];
    assign w_rs     = InstrIn[INSTR_W-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
    assign w_imm    = InstrIn[IMM_W-1:0];
    assign w_rt     = InstrIn[IMM_W-1 -: REG_SEL_W];

    if (DATA_W > IMM_W) begin : g_ext_wide
        logic w_fill;
        assign w_fill    = (SIGN_EXT != 0) & w_imm[IMM_W-1];
        assign w_imm_ext = {{(DATA_W-IMM_W){w_fill}}, w_imm};
    end else begin : g_ext_same
        assign w_imm_ext = w_imm;
    end

    always_comb begin
        w_dec     = '0;
        w_dec.ds  = w_opcode[3];
        w_dec.alu = w_opcode[2:0];
        w_dec.we  = w_opcode[4] & (w_opcode != '0);
        w_dec.rs1 = w_rs;
        w_dec.rs2 = w_opcode[3] ? '0 : w_rt;
        w_dec.ws  = w_rd;
        w_dec.imm = w_imm_ext;
    end

    // ------------------------------------------------------------------
    // Skid control
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   r_in_ready;
    dec_t   r_main;
    dec_t   r_skid;
    logic   w_accept;
    logic   w_consume;
    logic   w_load_main;
    logic   w_load_skid;
    logic   w_main_from_skid;

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = r_in_ready;
    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_ONE;
                    w_load_main  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_next = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_consume) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_consume) begin
                    w_state_next     = ST_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
        // A flushed beat is dropped; the main entry keeps its stale contents.
        if (flush) begin
            w_state_next     = ST_EMPTY;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_TWO);
            if (w_load_main) begin
                r_main <= w_dec;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign S1_ReadSelect1 = r_main.rs1;
    assign S1_ReadSelect2 = r_main.rs2;
    assign S1_WriteSelect = r_main.ws;
    assign S1_WriteEnable = r_main.we;
    assign S1_DataSrc     = r_main.ds;
    assign S1_ALUOp       = r_main.alu;
    assign S1_IMM         = r_main.imm;

endmodule
`default_nettype wire

// File: tb/tb_s1_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_s1_decode_stage
// Purpose  : Directed and random checks of s1_decode_stage (sign- and
//            zero-extending instances) against a FIFO reference model.
// Revision : 1.0
// ============================================================================
module tb_s1_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] InstrIn;
    logic        in_valid;
    logic        out_ready;

    logic        sx_in_ready, sx_out_valid, sx_we, sx_ds;
    logic [4:0]  sx_rs1, sx_rs2, sx_ws;
    logic [2:0]  sx_alu;
    logic [31:0] sx_imm;
    logic        zx_in_ready, zx_out_valid, zx_we, zx_ds;
    logic [4:0]  zx_rs1, zx_rs2, zx_ws;
    logic [2:0]  zx_alu;
    logic [31:0] zx_imm;

    always #5 clk = ~clk;

    s1_decode_stage #(.SIGN_EXT(1)) u_dut_sx (
        .clk(clk), .rst(rst), .flush(flush), .InstrIn(InstrIn),
        .in_valid(in_valid), .in_ready(sx_in_ready), .out_ready(out_ready),
        .out_valid(sx_out_valid), .S1_ReadSelect1(sx_rs1), .S1_ReadSelect2(sx_rs2),
        .S1_WriteSelect(sx_ws), .S1_WriteEnable(sx_we), .S1_DataSrc(sx_ds),
        .S1_ALUOp(sx_alu), .S1_IMM(sx_imm)
    );

    s1_decode_stage #(.SIGN_EXT(0)) u_dut_zx (
        .clk(clk), .rst(rst), .flush(flush), .InstrIn(InstrIn),
        .in_valid(in_valid), .in_ready(zx_in_ready), .out_ready(out_ready),
        .out_valid(zx_out_valid), .S1_ReadSelect1(zx_rs1), .S1_ReadSelect2(zx_rs2),
        .S1_WriteSelect(zx_ws), .S1_WriteEnable(zx_we), .S1_DataSrc(zx_ds),
        .S1_ALUOp(zx_alu), .S1_IMM(zx_imm)
    );

    typedef struct {
        int unsigned rs1, rs2, ws, we, ds, alu, imm_s, imm_z;
    } exp_t;

    exp_t        q[$];
    bit          m_ready;
    bit          m_rst_zero;
    int          tests = 0;
    int          fails = 0;

    // Reference decode from the field layout, using plain integer arithmetic.
    function automatic exp_t ref_decode(input int unsigned ins);
        exp_t e;
        int unsigned opc, imm;
        opc     = ins >> 26;
        imm     = ins % 65536;
        e.ws    = (ins >> 21) % 32;
        e.rs1   = (ins >> 16) % 32;
        e.ds    = (opc / 8) % 2;
        e.alu   = opc % 8;
        e.we    = (opc != 0 && ((opc / 16) % 2) == 1) ? 1 : 0;
        e.rs2   = e.ds ? 0 : (imm / 2048) % 32;
        e.imm_z = imm;
        e.imm_s = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("sx_out_valid", {31'd0, sx_out_valid}, {31'd0, q.size() != 0});
        chk("zx_out_valid", {31'd0, zx_out_valid}, {31'd0, q.size() != 0});
        chk("sx_in_ready",  {31'd0, sx_in_ready},  {31'd0, m_ready});
        chk("zx_in_ready",  {31'd0, zx_in_ready},  {31'd0, m_ready});
        if (q.size() != 0) begin
            chk("rs1",   {27'd0, sx_rs1}, q[0].rs1);
            chk("rs2",   {27'd0, sx_rs2}, q[0].rs2);
            chk("ws",    {27'd0, sx_ws},  q[0].ws);
            chk("we",    {31'd0, sx_we},  q[0].we);
            chk("ds",    {31'd0, sx_ds},  q[0].ds);
            chk("alu",   {29'd0, sx_alu}, q[0].alu);
            chk("imm_s", sx_imm,          q[0].imm_s);
            chk("imm_z", zx_imm,          q[0].imm_z);
            chk("zx_ws", {27'd0, zx_ws},  q[0].ws);
        end else if (m_rst_zero) begin
            chk("rst_sx_fields", {sx_rs1, sx_rs2, sx_ws, sx_we, sx_ds, sx_alu, 12'd0}, 32'd0);
            chk("rst_zx_fields", {zx_rs1, zx_rs2, zx_ws, zx_we, zx_ds, zx_alu, 12'd0}, 32'd0);
            chk("rst_sx_imm", sx_imm, 32'd0);
            chk("rst_zx_imm", zx_imm, 32'd0);
        end
    endtask

    // Drive one cycle at the negedge, advance the model at the posedge,
    // then compare at the following negedge.
    task automatic step(input bit r, input bit f, input bit v,
                        input logic [31:0] ins, input bit ordy);
        bit acc, con;
        rst = r; flush = f; in_valid = v; InstrIn = ins; out_ready = ordy;
        acc = v && m_ready;
        con = (q.size() != 0) && ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ready    = 0;
            m_rst_zero = 1;
        end else if (f) begin
            q.delete();
            m_ready = 1;
        end else begin
            if (con) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(ins));
                m_rst_zero = 0;
            end
            m_ready = (q.size() < 2);
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] c_itype = 32'h7421_000A;
    localparam logic [31:0] c_rtype = 32'h5461_1000;

    initial begin
        rst = 1; flush = 0; in_valid = 1; InstrIn = c_itype; out_ready = 1;
        m_ready = 0; m_rst_zero = 1;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a valid beat presented
        step(1, 0, 1, c_itype, 1);
        step(1, 0, 1, c_itype, 1);
        chk("rst_in_ready", {31'd0, sx_in_ready}, 32'd0);
        step(0, 0, 0, 32'd0, 1);
        chk("post_rst_in_ready", {31'd0, sx_in_ready}, 32'd1);

        // I-type, R-type back to back, sign extension, NOP
        step(0, 0, 1, c_itype, 1);
        chk("itype_imm", sx_imm, 32'h0000_000A);
        chk("itype_dec", {27'd0, sx_ws, sx_rs1, sx_rs2, sx_we, sx_ds, sx_alu},
            {27'd0, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 3'b101});
        step(0, 0, 1, c_rtype, 1);
        chk("rtype_dec", {27'd0, sx_ws, sx_rs1, sx_rs2, sx_we, sx_ds, sx_alu},
            {27'd0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 3'b101});
        step(0, 0, 1, 32'h7421_FFF6, 1);
        chk("sext_imm", sx_imm, 32'hFFFF_FFF6);
        chk("zext_imm", zx_imm, 32'h0000_FFF6);
        step(0, 0, 1, 32'h0000_0000, 1);
        chk("nop_we", {31'd0, sx_we}, 32'd0);
        step(0, 0, 0, 32'd0, 1);

        // Back-pressure fills both entries, then drains in order
        step(0, 0, 1, c_itype, 0);
        step(0, 0, 1, c_rtype, 0);
        chk("bp_in_ready", {31'd0, sx_in_ready}, 32'd0);
        chk("bp_hold_ws",  {27'd0, sx_ws}, 32'd1);
        step(0, 0, 1, c_itype, 0);
        chk("bp_stable_imm", sx_imm, 32'h0000_000A);
        step(0, 0, 0, 32'd0, 1);
        chk("bp_second_ws", {27'd0, sx_ws}, 32'd3);
        chk("bp_ready_back", {31'd0, sx_in_ready}, 32'd1);
        step(0, 0, 0, 32'd0, 1);
        chk("bp_drained", {31'd0, sx_out_valid}, 32'd0);

        // Flush with both entries full and a beat presented
        step(0, 0, 1, c_itype, 0);
        step(0, 0, 1, c_rtype, 0);
        step(0, 1, 1, c_itype, 0);
        chk("flush_valid", {31'd0, sx_out_valid}, 32'd0);
        chk("flush_ready", {31'd0, sx_in_ready},  32'd1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);

        // Reset together with flush
        step(0, 0, 1, c_rtype, 0);
        step(1, 1, 1, c_itype, 1);
        chk("rstflush_imm", sx_imm, 32'd0);
        step(0, 0, 1, c_itype, 1);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 7) == 0) ins[31:26] = 6'd0;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s1_decode_stage.md
Name: s1_decode_stage

Overview:
- Parametrised Stage-1 (decode) pipeline register with ready/valid handshake on both sides and a 2-entry skid buffer.
- Sits between instruction fetch and register-file read/ALU.
- Decodes each accepted instruction into register selects, write enable, data-source select, ALU op and an extended immediate.
- Supports back-pressure and a synchronous pipeline flush, which the previous fixed-width S1 register lacked.

Parameters:
- OPC_W, 6, opcode field width.
- REG_SEL_W, 5, register select field width.
- IMM_W, 16, immediate field width.
- INSTR_W, 32, instruction width. Must equal OPC_W+2*REG_SEL_W+IMM_W; otherwise elaboration fails.
- DATA_W, 32, width of extended immediate output (DATA_W >= IMM_W).
- SIGN_EXT, 1, 1 = sign-extend the immediate, 0 = zero-extend.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous pipeline flush.
- InstrIn  in  INSTR_W  instruction from fetch.
- in_valid  in  1  InstrIn valid.
- in_ready  out  1  stage can accept; registered.
- out_ready  in  1  downstream accepts current outputs.
- out_valid  out  1  decoded outputs valid.
- S1_ReadSelect1  out  REG_SEL_W  rs field.
- S1_ReadSelect2  out  REG_SEL_W  rt field (R-type), 0 (I-type).
- S1_WriteSelect  out  REG_SEL_W  rd field.
- S1_WriteEnable  out  1  register write enable.
- S1_DataSrc  out  1  1 = immediate operand, 0 = register operand.
- S1_ALUOp  out  3  ALU operation.
- S1_IMM  out  DATA_W  extended immediate.

Behaviour:
- Field decode. Bit positions:
  - opcode = InstrIn[INSTR_W-1 -: OPC_W].
  - rd = next REG_SEL_W bits.
  - rs = next REG_SEL_W bits.
  - imm = InstrIn[IMM_W-1:0].
  - rt = InstrIn[IMM_W-1 -: REG_SEL_W].
- Control decode:
  - DataSrc = opcode[3].
  - ALUOp = opcode[2:0].
  - WriteEnable = opcode[4], forced to 0 when opcode == 0 (NOP).
  - ReadSelect2 = rt when DataSrc = 0, else 0.
- Immediate extension: S1_IMM = imm extended to DATA_W, sign- or zero-extended per SIGN_EXT. It is produced for every instruction; downstream uses it only when DataSrc = 1.
- Decode is combinational on input. Only decoded fields are stored, never raw instructions.
- Handshake:
  - An input beat is accepted when in_valid & in_ready.
  - An output beat is consumed when out_valid & out_ready.
  - Outputs are stable while out_valid & !out_ready.
- Skid FSM has three states: EMPTY, ONE (main entry valid), TWO (main + skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept & !consume → TWO (beat goes to skid).
  - ONE: consume & !accept → EMPTY.
  - ONE: accept & consume → ONE (main reloaded).
  - TWO: consume → ONE (skid moves to main). No accept is possible in TWO.
- in_ready = 0 in TWO or during reset, else 1. It is a registered function of next state, so there is no combinational path from out_ready to in_ready.
- out_valid = 1 in ONE/TWO.
- Latency: 1 cycle from accept to out_valid when EMPTY. Full throughput (1 beat/cycle) when out_ready is held high.
- Ordering is strictly FIFO: main is always older than skid.
- flush:
  - Next state is EMPTY; out_valid = 0 and in_ready = 1 the following cycle.
  - A beat presented in the flush cycle is dropped.
  - A beat consumed in the flush cycle counts as delivered.
- rst:
  - Takes priority over flush and any handshake.
  - Next state is EMPTY; in_ready = 0 during rst, 1 the cycle after deassertion.
  - All decoded output registers = 0: selects 0, WriteEnable 0, DataSrc 0, ALUOp 0, S1_IMM 0.
  - Reset mid-transfer discards both entries.
- After flush, outputs hold their stale values but out_valid = 0. Output values while out_valid = 0 are don't-care, except after rst, where they are all 0.

Test Plan:
- Reset: rst = 1 for 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 0, all outputs 0. One cycle after rst drops, in_ready = 1.
- I-type: InstrIn = 0x7421000A, out_ready = 1 → next cycle out_valid = 1, WriteSelect = 1, ReadSelect1 = 1, ReadSelect2 = 0, WriteEnable = 1, DataSrc = 1, ALUOp = 3'b101, S1_IMM = 0x0000000A.
- R-type back-to-back after I-type: InstrIn = 0x54611000 on the following cycle → WriteSelect = 3, ReadSelect1 = 1, ReadSelect2 = 2, DataSrc = 0, ALUOp = 3'b101, WriteEnable = 1. Throughput is 1 beat/cycle.
- Sign extension: InstrIn = 0x7421FFF6 → S1_IMM = 0xFFFFFFF6 with SIGN_EXT = 1; 0x0000FFF6 in a second instance with SIGN_EXT = 0. InstrIn = 0x00000000 → WriteEnable = 0.
- Back-pressure: out_ready = 0, send 0x7421000A then 0x54611000 → in_ready = 0 after the second accept, outputs hold the I-type decode. Raise out_ready → I-type consumed, then R-type, in order; in_ready returns to 1 one cycle after the first consume.
- Flush in TWO state with in_valid = 1 (InstrIn = 0x7421000A) → next cycle out_valid = 0, in_ready = 1. Neither buffered beat nor the flush-cycle beat ever appears at the output. Assert rst together with flush → reset values.
